// File: rtl/hatch_sequencer_if.sv
// Operator inputs and display-side outputs of the hatch sequencer.
// The master drives the switches/button; the slave is the sequencer itself.
interface hatch_sequencer_if;
  logic       enable;
  logic       start;
  logic       heat;
  logic [2:0] state;
  logic [4:0] frame;
  logic [6:0] elapsed;
  logic       tick;
  logic       disp_en;
  logic       led_fail;
  logic       led_heat;

  modport master (
    output enable, start, heat,
    input  state, frame, elapsed, tick, disp_en, led_fail, led_heat
  );

  modport slave (
    input  enable, start, heat,
    output state, frame, elapsed, tick, disp_en, led_fail, led_heat
  );
endinterface

// File: rtl/hatch_sequencer.sv
// Hatch-cycle controller: owns the 1 s time base, animation frame index,
// cold-exposure timeout and elapsed-seconds counter for the display path.
module hatch_sequencer #(
  parameter int TICK_DIV    = 1000,
  parameter int FRAME_SEC   = 2,
  parameter int GROW_START  = 10,
  parameter int HATCH_FRAME = 16,
  parameter int COLD_LIMIT  = 5
) (
  input  logic              clk,
  input  logic              rst,
  hatch_sequencer_if.slave  bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int PH_W  = (FRAME_SEC > 1) ? $clog2(FRAME_SEC) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(FRAME_SEC - 1);
  localparam logic [4:0]       GROW_F    = 5'(GROW_START);
  localparam logic [4:0]       HATCH_F   = 5'(HATCH_FRAME);
  localparam logic [2:0]       COLD_MAX  = 3'(COLD_LIMIT);
  localparam logic [6:0]       ELAPS_MAX = 7'd99;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READY    = 3'd1,
    S_INCUBATE = 3'd2,
    S_GROW     = 3'd3,
    S_HATCHED  = 3'd4,
    S_FAILED   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [4:0]       frame_q, frame_d;
  logic [6:0]       elapsed_q, elapsed_d;
  logic [2:0]       cold_q, cold_d;
  logic             running_q, running_d, tick_w;

  function automatic logic [4:0] sat_frame(input logic [4:0] v);
    return (v >= HATCH_F) ? HATCH_F : v + 5'd1;
  endfunction

  function automatic logic [6:0] sat_elapsed(input logic [6:0] v);
    return (v >= ELAPS_MAX) ? ELAPS_MAX : v + 7'd1;
  endfunction

  function automatic logic [2:0] sat_cold(input logic [2:0] v);
    return (v >= COLD_MAX) ? COLD_MAX : v + 3'd1;
  endfunction

  assign running_q = (state_q == S_INCUBATE) || (state_q == S_GROW);
  assign running_d = (state_d == S_INCUBATE) || (state_d == S_GROW);
  assign tick_w    = running_q && (pre_q == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Transition checks run on registered counters; fail outranks grow.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_READY;
        S_READY:    if (bus.start) state_d = S_INCUBATE;
        S_INCUBATE: begin
          if (cold_q == COLD_MAX)      state_d = S_FAILED;
          else if (frame_q == GROW_F)  state_d = S_GROW;
        end
        S_GROW:     if (frame_q == HATCH_F) state_d = S_HATCHED;
        S_HATCHED,
        S_FAILED:   if (bus.start) state_d = S_READY;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_d     = pre_q;
    phase_d   = phase_q;
    frame_d   = frame_q;
    elapsed_d = elapsed_q;
    cold_d    = cold_q;
    if (state_d == S_IDLE || state_d == S_READY || state_q == S_READY) begin
      pre_d     = '0;
      phase_d   = '0;
      frame_d   = '0;
      elapsed_d = '0;
      cold_d    = '0;
    end else if (running_q) begin
      pre_d = (tick_w || !running_d) ? '0 : pre_q + PRE_W'(1);
      if (tick_w) begin
        elapsed_d = sat_elapsed(elapsed_q);
        if (phase_q == PH_MAX) begin
          phase_d = '0;
          frame_d = sat_frame(frame_q);
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      // Cold exposure only accumulates while staying in INCUBATE.
      if (state_q != S_INCUBATE || state_d != S_INCUBATE || bus.heat) cold_d = '0;
      else if (tick_w)                                                   cold_d = sat_cold(cold_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      phase_q   <= '0;
      frame_q   <= '0;
      elapsed_q <= '0;
      cold_q    <= '0;
    end else begin
      pre_q     <= pre_d;
      phase_q   <= phase_d;
      frame_q   <= frame_d;
      elapsed_q <= elapsed_d;
      cold_q    <= cold_d;
    end
  end

  always_comb begin
    bus.state    = state_q;
    bus.frame    = frame_q;
    bus.elapsed  = elapsed_q;
    bus.tick     = tick_w;
    bus.disp_en  = (state_q != S_IDLE);
    bus.led_fail = (state_q == S_FAILED);
    bus.led_heat = bus.heat && running_q;
  end

endmodule

// File: tb/tb_hatch_sequencer.sv
// Directed bench for hatch_sequencer with TICK_DIV = 4, FRAME_SEC = 2.
module tb_hatch_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  hatch_sequencer_if bus ();

  hatch_sequencer #(
    .TICK_DIV(4), .FRAME_SEC(2), .GROW_START(10), .HATCH_FRAME(16), .COLD_LIMIT(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    bus.heat   = 1'b1;
    repeat (3) step();

    // Reset and power-up
    chk("rst_state",    bus.state, 0);
    chk("rst_frame",    bus.frame, 0);
    chk("rst_elapsed",  bus.elapsed, 0);
    chk("rst_tick",     bus.tick, 0);
    chk("rst_disp_en",  bus.disp_en, 0);
    chk("rst_led_fail", bus.led_fail, 0);
    chk("rst_led_heat", bus.led_heat, 0);
    rst = 1'b0;
    chk("rel_state0", bus.state, 0);
    step();
    chk("rel_state1", bus.state, 1);
    chk("rel_disp_en", bus.disp_en, 1);

    // Nominal hatch, heat held high
    pulse_start();
    chk("nom_c0_state", bus.state, 2);
    chk("nom_c0_led_heat", bus.led_heat, 1);
    go(2);  chk("nom_c2_tick", bus.tick, 0);
    go(3);  chk("nom_c3_tick", bus.tick, 1);
    go(4);  chk("nom_c4_elapsed", bus.elapsed, 1);
    go(7);  chk("nom_c7_tick", bus.tick, 1);
    go(8);  chk("nom_c8_frame", bus.frame, 1);
    go(80); chk("nom_c80_frame", bus.frame, 10);
            chk("nom_c80_state", bus.state, 2);
    go(81); chk("nom_c81_state", bus.state, 3);
    go(90);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("nom_grow_start_ignored", bus.state, 3);
    go(128); chk("nom_c128_frame", bus.frame, 16);
             chk("nom_c128_state", bus.state, 3);
    go(129); chk("nom_c129_state", bus.state, 4);
             chk("nom_c129_elapsed", bus.elapsed, 32);
             chk("nom_c129_led_heat", bus.led_heat, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("nom_hatched_tick", bus.tick, 0);
    end
    chk("nom_frozen_frame", bus.frame, 16);
    chk("nom_frozen_elapsed", bus.elapsed, 32);
    pulse_start();
    chk("nom_rearm_state", bus.state, 1);
    chk("nom_rearm_frame", bus.frame, 0);
    chk("nom_rearm_elapsed", bus.elapsed, 0);

    // Cold fail, heat low from start
    bus.heat = 1'b0;
    pulse_start();
    chk("cold_c0_led_heat", bus.led_heat, 0);
    go(20); chk("cold_c20_cold", dut.cold_q, 5);
            chk("cold_c20_state", bus.state, 2);
    go(21); chk("cold_c21_state", bus.state, 5);
            chk("cold_c21_frame", bus.frame, 2);
            chk("cold_c21_elapsed", bus.elapsed, 5);
            chk("cold_c21_led_fail", bus.led_fail, 1);
    pulse_start();
    chk("cold_rearm_state", bus.state, 1);
    chk("cold_rearm_led_fail", bus.led_fail, 0);

    // Heat glitch: 4 cold seconds, one warm cycle, then cold again
    pulse_start();
    go(16); chk("glitch_c16_cold", dut.cold_q, 4);
    bus.heat = 1'b1;
    step();
    bus.heat = 1'b0;
    chk("glitch_c17_cold", dut.cold_q, 0);
    go(36); chk("glitch_c36_state", bus.state, 2);
    go(37); chk("glitch_c37_state", bus.state, 5);
    pulse_start();

    // Cold timeout and grow threshold land on the same cycle
    bus.heat = 1'b1;
    pulse_start();
    go(60); bus.heat = 1'b0;
    go(80); chk("simul_c80_frame", bus.frame, 10);
            chk("simul_c80_cold", dut.cold_q, 5);
    go(81); chk("simul_c81_state", bus.state, 5);
    pulse_start();

    // Enable dropped mid-incubation
    bus.heat = 1'b1;
    pulse_start();
    go(50); chk("en_c50_elapsed", bus.elapsed, 12);
            chk("en_c50_frame", bus.frame, 6);
    bus.enable = 1'b0;
    go(51); chk("en_c51_state", bus.state, 0);
            chk("en_c51_frame", bus.frame, 0);
            chk("en_c51_elapsed", bus.elapsed, 0);
            chk("en_c51_disp_en", bus.disp_en, 0);

    // Reset mid-incubation
    bus.enable = 1'b1;
    step();
    chk("rst2_ready", bus.state, 1);
    pulse_start();
    go(10);
    rst = 1'b1;
    step();
    chk("rst2_state", bus.state, 0);
    chk("rst2_elapsed", bus.elapsed, 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hatch_sequencer.md
# hatch_sequencer

Controller for the egg-hatching display datapath. It sequences one hatch cycle from operator inputs: IDLE, READY, INCUBATE, GROW, then HATCHED or FAILED. It owns the 1 s time base, the animation frame index for the dot-matrix renderer, the cold-exposure timeout and the elapsed-seconds value for the seven-segment driver. It sits between the debounced button / switch inputs and the display modules, and replaces the enable registers currently scattered across the top level.

## Interface
- TICK_DIV, 1000: clk cycles per 1 s tick (at least 2).
- FRAME_SEC, 2: seconds per animation frame (at least 1).
- GROW_START, 10: frame index that ends INCUBATE.
- HATCH_FRAME, 16: frame index that ends GROW (greater than GROW_START, at most 31).
- COLD_LIMIT, 5: consecutive cold seconds that fail an incubation (1..7).
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  power switch (sw7), level, already synchronised.
- start  in  1  debounced single-cycle button pulse (btn0).
- heat  in  1  heater switch (sw0), level; 1 = warm.
- state  out  3  0 IDLE, 1 READY, 2 INCUBATE, 3 GROW, 4 HATCHED, 5 FAILED.
- frame  out  5  animation frame index for the matrix renderer.
- elapsed  out  7  seconds since incubation start, 0..99.
- tick  out  1  one-cycle 1 s pulse, active only in INCUBATE and GROW.
- disp_en  out  1  1 when state is not IDLE.
- led_fail  out  1  1 when state is FAILED.
- led_heat  out  1  heat AND state is INCUBATE or GROW; this is the only input-combinational output.

## Operation
- The prescaler pre counts 0..TICK_DIV-1 only in INCUBATE and GROW. tick = (pre == TICK_DIV-1), then pre wraps to 0. In any other state pre is held at 0.
- phase counts ticks 0..FRAME_SEC-1. On the tick where phase == FRAME_SEC-1, phase goes to 0 and frame increments. frame saturates at HATCH_FRAME.
- elapsed increments on every tick and saturates at 99.
- cold (3 bits) exists only in INCUBATE:
  - it clears on any cycle where heat = 1;
  - it increments on a tick while heat = 0;
  - it saturates at COLD_LIMIT.
- Transitions are evaluated on registered values. Checks run in the order listed; the first match wins.
  - Any state, enable = 0: go to IDLE. frame, elapsed, phase, cold and pre all clear.
  - IDLE: enable = 1 goes to READY.
  - READY: start goes to INCUBATE. frame, elapsed, phase, cold and pre clear on entry.
  - INCUBATE: cold == COLD_LIMIT goes to FAILED. Otherwise frame == GROW_START goes to GROW. Fail has priority when both hold in the same cycle.
  - GROW: heat is ignored and cold is held at 0. frame == HATCH_FRAME goes to HATCHED.
  - HATCHED / FAILED: frame, elapsed and tick are frozen. start goes to READY, with counters cleared.
- start is ignored in IDLE, INCUBATE and GROW.
- pre and phase carry across INCUBATE to GROW without reset.

## Timing
- Reset values: state = 0, frame = 0, elapsed = 0, tick = 0, disp_en = 0, led_fail = 0, led_heat = 0. Internal pre, phase and cold are 0.
- All outputs except led_heat come from registers: state-to-output latency is 0, input-to-state latency is 1 cycle.
- Cycle n is defined as the nth cycle with state == INCUBATE, starting at n = 0. With TICK_DIV = 4 and FRAME_SEC = 2:
  - tick is high at cycles 3, 7, 11, …;
  - elapsed = 1 at cycle 4;
  - frame = 1 at cycle 8;
  - frame = 10 at cycle 80, state = GROW at cycle 81;
  - frame = 16 at cycle 128, state = HATCHED at cycle 129, elapsed frozen at 32.
- Cold timeout: cold reaches COLD_LIMIT at the cycle after the COLD_LIMIT-th consecutive cold tick, and state = FAILED one cycle later.
- rst takes effect at the next clk edge from any state, including mid-operation.
- An enable drop mid-incubation reaches IDLE in 1 cycle.

## Test plan
All scenarios use TICK_DIV = 4 and FRAME_SEC = 2 unless stated.
- Reset and power-up: hold rst with enable = 1, then release → state 0 at the first edge after release, then 1; all outputs 0 during reset.
- Nominal hatch with heat = 1: after start → GROW at INCUBATE cycle 81, HATCHED at cycle 129, frame = 16, elapsed = 32, tick silent afterwards; start then returns to READY with frame = 0.
- Cold fail with heat = 0 from start → cold = 5 at cycle 20, FAILED at cycle 21, frame = 2, led_fail = 1.
- Heat glitch: heat low for 4 s, high for 1 cycle, then low again → cold restarts from 0; no FAIL before 9 s total.
- Simultaneous events: heat goes low at cycle 60 (15 s) → frame = 10 and cold = 5 both at cycle 80 → state FAILED, not GROW.
- enable dropped at INCUBATE cycle 50 → IDLE at cycle 51 with frame = 0, elapsed = 0, disp_en = 0. A start pulse in GROW is ignored.
